// File: rtl/reg_file_bank_if.sv
// Register file bank port bundle: write port, two read ports and clear control.
// master drives requests, slave is the register file.
interface reg_file_bank_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] BusMuxOut;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [DATA_W-1:0] rd_a_data;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] rd_b_data;
    logic              init_req;
    logic              busy;
    logic              wr_err;

    modport master (
        output wr_en, wr_addr, BusMuxOut,
        output rd_a_addr, rd_b_addr, init_req,
        input  rd_a_data, rd_b_data, busy, wr_err
    );

    modport slave (
        input  wr_en, wr_addr, BusMuxOut,
        input  rd_a_addr, rd_b_addr, init_req,
        output rd_a_data, rd_b_data, busy, wr_err
    );
endinterface

// File: rtl/reg_file_bank.sv
// Register file with one write port, two registered write-first read ports
// and a sequential clear sweep. Optional macro REGFILE_R0_ZERO_EN ties reg 0 to zero.
module reg_file_bank #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16
) (
    input logic               clk,
    input logic               clr,
    reg_file_bank_if.slave    bus
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W:0]   NREG = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              busy_q;
    logic              wr_err_q;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rd_a_q;
    logic [DATA_W-1:0] rd_b_q;

    logic              w_en;
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] rd_a_nxt;
    logic [DATA_W-1:0] rd_b_nxt;

    // Select this cycle's single register write: the sweep owns the port in CLEAR.
    always_comb begin
        w_en   = 1'b0;
        w_idx  = bus.wr_addr;
        w_data = bus.BusMuxOut;
        if (state == CLEAR) begin
            w_en   = 1'b1;
            w_idx  = cnt;
            w_data = '0;
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < NREG)) begin
            w_en = 1'b1;
        end
`ifdef REGFILE_R0_ZERO_EN
        if (w_idx == '0) w_en = 1'b0;
`endif
    end

    // Read muxes with write-first bypass; out-of-range indices read zero.
    always_comb begin
        rd_a_nxt = '0;
        rd_b_nxt = '0;
        if ({1'b0, bus.rd_a_addr} < NREG) begin
            if (w_en && w_idx == bus.rd_a_addr) rd_a_nxt = w_data;
            else                                rd_a_nxt = regs[bus.rd_a_addr];
        end
        if ({1'b0, bus.rd_b_addr} < NREG) begin
            if (w_en && w_idx == bus.rd_b_addr) rd_b_nxt = w_data;
            else                                rd_b_nxt = regs[bus.rd_b_addr];
        end
`ifdef REGFILE_R0_ZERO_EN
        if (bus.rd_a_addr == '0) rd_a_nxt = '0;
        if (bus.rd_b_addr == '0) rd_b_nxt = '0;
`endif
    end

    // Clear-sweep FSM with registered busy and write-rejection pulse.
    always_ff @(posedge clk) begin
        if (clr) begin
            state    <= IDLE;
            cnt      <= '0;
            busy_q   <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            wr_err_q <= bus.wr_en && (state == CLEAR);
            unique case (state)
                IDLE: begin
                    if (bus.init_req) begin
                        state  <= CLEAR;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state  <= IDLE;
                        cnt    <= '0;
                        busy_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Register array and registered read data.
    always_ff @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else begin
            if (w_en) regs[w_idx] <= w_data;
            rd_a_q <= rd_a_nxt;
            rd_b_q <= rd_b_nxt;
        end
    end

    assign bus.rd_a_data = rd_a_q;
    assign bus.rd_b_data = rd_b_q;
    assign bus.busy      = busy_q;
    assign bus.wr_err    = wr_err_q;
endmodule

// File: tb/tb_reg_file_bank.sv
// Randomized bench for reg_file_bank against an array/queue reference model.
// Build with +define+REGFILE_R0_ZERO_EN to check the hardwired-zero variant.
module tb_reg_file_bank;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;

    logic clk = 1'b0;
    logic clr = 1'b1;

    reg_file_bank_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_file_bank #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] m_regs [NR];
    int            clr_q [$];
    int            n_chk  = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [DW-1:0] m_rd(input logic [AW-1:0] a);
        if (int'(a) >= NR) return '0;
`ifdef REGFILE_R0_ZERO_EN
        if (a == '0) return '0;
`endif
        return m_regs[a];
    endfunction

    // Advance the model by one edge, clock the DUT, then compare outputs.
    task automatic step();
        logic          was_busy;
        logic          e_err;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        ra = bus.rd_a_addr;
        rb = bus.rd_b_addr;
        was_busy = clr_q.size() != 0;
        e_err = 1'b0;
        if (clr) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            clr_q.delete();
        end else begin
            e_err = bus.wr_en && was_busy;
            if (was_busy) begin
                m_regs[clr_q.pop_front()] = '0;
            end else begin
                if (bus.wr_en && int'(bus.wr_addr) < NR) begin
`ifdef REGFILE_R0_ZERO_EN
                    if (bus.wr_addr != '0) m_regs[bus.wr_addr] = bus.BusMuxOut;
`else
                    m_regs[bus.wr_addr] = bus.BusMuxOut;
`endif
                end
                if (bus.init_req)
                    for (int i = 0; i < NR; i++) clr_q.push_back(i);
            end
        end
        @(posedge clk);
        #1;
        chk("rd_a", bus.rd_a_data, m_rd(ra));
        chk("rd_b", bus.rd_b_data, m_rd(rb));
        chk("busy", {31'd0, bus.busy}, {31'd0, clr_q.size() != 0});
        chk("wr_err", {31'd0, bus.wr_err}, {31'd0, e_err});
    endtask

    task automatic idle_in();
        bus.wr_en     = 1'b0;
        bus.init_req  = 1'b0;
        bus.wr_addr   = '0;
        bus.BusMuxOut = '0;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        bus.wr_en     = 1'b1;
        bus.wr_addr   = AW'(a);
        bus.BusMuxOut = d;
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 0; i < NR; i++) wr(i, $urandom | 32'h1);
    endtask

    initial begin
        int busy_n;
        int err_n;
        idle_in();
        bus.rd_a_addr = '0;
        bus.rd_b_addr = '0;

        // reset state
        step();
        clr = 1'b0;

        // random writes, then a two-cycle clear
        for (int i = 0; i < 30; i++) wr($urandom_range(0, NR-1), $urandom);
        clr = 1'b1;
        step();
        step();
        clr = 1'b0;
        for (int i = 0; i < NR/2; i++) begin
            bus.rd_a_addr = AW'(i);
            bus.rd_b_addr = AW'(i + NR/2);
            step();
            chk("clr_rd_a", bus.rd_a_data, '0);
            chk("clr_rd_b", bus.rd_b_data, '0);
        end

        // write reg 5, read it next cycle
        wr(5, 32'hDEADBEEF);
        bus.rd_a_addr = 4'd5;
        step();
        chk("rd5", bus.rd_a_data, 32'hDEADBEEF);

        // same-cycle bypass on port B
        bus.rd_b_addr = 4'd3;
        wr(3, 32'h12345678);
        chk("bypass3", bus.rd_b_data, 32'h12345678);

        // clear sweep with a rejected write
        fill_all();
        bus.init_req = 1'b1;
        step();
        bus.init_req = 1'b0;
        busy_n = int'(bus.busy);
        err_n  = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) begin
                bus.wr_en     = 1'b1;
                bus.wr_addr   = 4'd7;
                bus.BusMuxOut = 32'hAA;
            end else begin
                bus.wr_en = 1'b0;
            end
            step();
            busy_n += int'(bus.busy);
            err_n  += int'(bus.wr_err);
        end
        chk("busy_len", busy_n, 16);
        chk("err_pulses", err_n, 1);
        bus.rd_a_addr = 4'd7;
        step();
        chk("r7_zero", bus.rd_a_data, '0);

        // abort sweep with clr, then restart
        fill_all();
        bus.init_req = 1'b1;
        step();
        bus.init_req = 1'b0;
        for (int i = 0; i < 3; i++) step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, '0);
        for (int i = 0; i < NR/2; i++) begin
            bus.rd_a_addr = AW'(i);
            bus.rd_b_addr = AW'(i + NR/2);
            step();
            chk("abort_rd_a", bus.rd_a_data, '0);
            chk("abort_rd_b", bus.rd_b_data, '0);
        end
        fill_all();
        bus.rd_a_addr = 4'd0;
        bus.rd_b_addr = 4'd1;
        bus.init_req  = 1'b1;
        step();
        bus.init_req = 1'b0;
        step();
        chk("restart_r0", bus.rd_a_data, '0);
        chk("restart_r1", {31'd0, bus.rd_b_data != '0}, 32'd1);
        for (int i = 0; i < NR; i++) step();

        // reg 0 behaviour
        wr(0, 32'h55);
        chk("r0_err", {31'd0, bus.wr_err}, '0);
        bus.rd_a_addr = 4'd0;
        step();
`ifdef REGFILE_R0_ZERO_EN
        chk("r0_rd", bus.rd_a_data, 32'h0);
`else
        chk("r0_rd", bus.rd_a_data, 32'h55);
`endif

        // random traffic
        for (int i = 0; i < 400; i++) begin
            clr           = ($urandom_range(0, 49) == 0);
            bus.init_req  = ($urandom_range(0, 29) == 0);
            bus.wr_en     = $urandom_range(0, 1) == 1;
            bus.wr_addr   = AW'($urandom_range(0, NR-1));
            bus.BusMuxOut = $urandom;
            bus.rd_a_addr = AW'($urandom_range(0, NR-1));
            bus.rd_b_addr = AW'($urandom_range(0, NR-1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_file_bank.md
REG_FILE_BANK -- requirements
Module: reg_file_bank

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 32, register and bus width in bits.
- NUM_REGS, 16, number of registers (2..64).
- ADDR_W, derived as ceil(log2(NUM_REGS)), not user-set.

REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- clr  in  1  reset, synchronous, active-high.
- wr_en  in  1  write request.
- wr_addr  in  ADDR_W  write register index.
- BusMuxOut  in  DATA_W  write data from the bus.
- rd_a_addr  in  ADDR_W  read port A index.
- rd_a_data  out  DATA_W  read port A data, registered.
- rd_b_addr  in  ADDR_W  read port B index.
- rd_b_data  out  DATA_W  read port B data, registered.
- init_req  in  1  request to clear all registers in sequence.
- busy  out  1  clear sequence in progress.
- wr_err  out  1  one-cycle pulse: a write was rejected.

REQ-003 The block SHALL use one clock and a synchronous, active-high reset, with the clock named clk and the reset named clr.

Function
REQ-004 A write SHALL be accepted when wr_en=1, busy=0 and wr_addr<NUM_REGS; reg[wr_addr] SHALL take BusMuxOut at that edge.
REQ-005 A write with wr_addr>=NUM_REGS SHALL be discarded with no wr_err and no other side effect.
REQ-006 Each read port SHALL have 1-cycle latency: at each edge rd_x_data SHALL load reg[rd_x_addr], or 0 if rd_x_addr>=NUM_REGS.
REQ-007 Read ports SHALL be write-first: if a write (REQ-004) or a clear-write (REQ-010) targets the same index in the same cycle, rd_x_data SHALL load the new value.
REQ-008 Ports A and B SHALL operate independently and may address the same register.
REQ-009 The FSM SHALL have states IDLE and CLEAR; busy SHALL be 1 exactly when in CLEAR.
REQ-010 Clear sequence:
- IDLE with init_req=1: go to CLEAR and set cnt=0.
- Each cycle in CLEAR: write 0 to reg[cnt], then cnt+1.
- When cnt=NUM_REGS-1 is cleared: return to IDLE.
- busy SHALL be high for exactly NUM_REGS cycles.
REQ-011 init_req while in CLEAR SHALL be ignored.
REQ-012 wr_en=1 while busy=1 SHALL be dropped, and wr_err SHALL be 1 on the following cycle only.
REQ-013 wr_en and init_req asserted together in IDLE:
- The write SHALL be accepted.
- CLEAR SHALL start at the same edge.
- The written register SHALL later be zeroed by the sweep.
REQ-014 Reads during CLEAR SHALL return current contents, including registers already zeroed.

Reset
REQ-015 While clr=1 at an edge, the block SHALL:
- set all registers, rd_a_data, rd_b_data, cnt, busy and wr_err to 0;
- set the FSM to IDLE.
REQ-016 clr SHALL take priority over wr_en and init_req.
REQ-017 clr during CLEAR SHALL abort the sequence, and the FSM SHALL be in IDLE on the next cycle.

Configuration
REQ-018 Macro REGFILE_R0_ZERO_EN:
- Defined: reg[0] is hardwired to 0, reads of index 0 return 0 (bypass included), and writes to index 0 are discarded silently with no wr_err.
- Undefined: reg[0] is an ordinary register.

Verification
REQ-019 The bench SHALL cover these scenarios:
- clr=1 for 2 cycles after random writes -> all reads return 0x00000000; busy=0; wr_err=0.
- Write 0xDEADBEEF to reg 5, then read A=5 next cycle -> rd_a_data=0xDEADBEEF one cycle after the address is applied.
- Same-cycle write 0x12345678 to reg 3 with rd_b_addr=3 -> rd_b_data=0x12345678 at that edge (bypass).
- Fill all regs, pulse init_req, write 0xAA to reg 7 during busy -> busy high for 16 cycles, wr_err pulses once, reg 7 reads 0 afterwards.
- Assert clr at cycle 4 of CLEAR -> busy=0 next cycle; all registers read 0; a new init_req then restarts at cnt=0.
- With REGFILE_R0_ZERO_EN, write 0x55 to reg 0 -> reg 0 reads 0, wr_err=0; without the macro -> reg 0 reads 0x55.
